// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: the data word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int RAM_DEFAULT_LAT = 2;

endpackage

// File: rtl/ram_responder_if.sv
// RAM request bus between the cache/memory arbiter (master) and the RAM (slave).
interface ram_responder_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_responder_ram_array.sv
// Single-port synchronous word storage; read data is registered every cycle.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             wen,
  input  logic [IDX_W-1:0] windex,
  input  word_t            wdata,
  input  logic [IDX_W-1:0] rindex,
  output word_t            rdata
);

  word_t mem [DEPTH];

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge CLK) begin
    if (wen) mem[windex] <= wdata;
    rdata <= mem[rindex];
  end

endmodule

// File: rtl/ram_responder.sv
// RAM responder: fixed-latency word RAM behind the arbiter with
// FREE/BUSY/ACCESS/ERROR handshake state.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT   = RAM_DEFAULT_LAT,
  parameter int DEPTH = 1024
) (
  input logic            CLK,
  input logic            RST,
  ram_responder_if.slave ram
);

  localparam int IDX_W = $clog2(DEPTH);

  ramstate_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  word_t      addr_q, addr_d;
  word_t      data_q, data_d;
  logic       ren_q, ren_d;
  logic       wen_q, wen_d;
  word_t      hold_q;
  logic       rsel_q;
  word_t      rdata;
  logic       array_wen;

  logic req, legal, match, done, evaluate;

  assign req   = ram.ramREN | ram.ramWEN;
  assign legal = !(ram.ramREN && ram.ramWEN) &&
                 (ram.ramaddr[1:0] == 2'b00) &&
                 (ram.ramaddr < word_t'(DEPTH * 4));
  // The pending access survives only while the requester holds it unchanged.
  assign match = req && (ram.ramREN == ren_q) && (ram.ramWEN == wen_q) &&
                 (ram.ramaddr == addr_q) && (ram.ramstore == data_q);
  assign done  = (state_q == BUSY) && match && (cnt_q == 4'd0);

  // A reset landing on the completing edge must suppress the write.
  assign array_wen = done && wen_q && !RST;

  ram_array #(.DEPTH(DEPTH)) u_array (
    .CLK    (CLK),
    .wen    (array_wen),
    .windex (addr_q[IDX_W+1:2]),
    .wdata  (data_q),
    .rindex (addr_q[IDX_W+1:2]),
    .rdata  (rdata)
  );

  // Next-state, counter and request-latch logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    evaluate = 1'b0;
    case (state_q)
      FREE:   evaluate = 1'b1;
      BUSY: begin
        if (!match)              evaluate = 1'b1;
        else if (cnt_q != 4'd0)  cnt_d    = cnt_q - 4'd1;
        else                     state_d  = ACCESS;
      end
      ACCESS: evaluate = 1'b1;
      ERROR:  if (!req) state_d = FREE;
      default: state_d = FREE;
    endcase
    if (evaluate) begin
      if (!req) begin
        state_d = FREE;
      end else if (!legal) begin
        state_d = ERROR;
      end else begin
        state_d = BUSY;
        cnt_d   = 4'(LAT - 1);
        addr_d  = ram.ramaddr;
        data_d  = ram.ramstore;
        ren_d   = ram.ramREN;
        wen_d   = ram.ramWEN;
      end
    end
  end

  // State, counter and latched request registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
    end
  end

  // Read result: array output is live during a read ACCESS, then parked in hold_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsel_q <= 1'b0;
      hold_q <= '0;
    end else begin
      rsel_q <= done && ren_q;
      if (rsel_q) hold_q <= rdata;
    end
  end

  assign ram.ramload  = rsel_q ? rdata : hold_q;
  assign ram.ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder (LAT=2, DEPTH=1024).
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   n_total  = 0;
  int   n_passed = 0;

  ram_responder_if rif ();

  ram_responder #(.LAT(2), .DEPTH(1024)) dut (
    .CLK (CLK),
    .RST (RST),
    .ram (rif.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_st(input string tag, input ramstate_t exp);
    chk(tag, 32'(rif.ramstate), 32'(exp));
  endtask

  task automatic drive(input logic ren, input logic wen, input word_t a, input word_t d);
    rif.ramREN   = ren;
    rif.ramWEN   = wen;
    rif.ramaddr  = a;
    rif.ramstore = d;
  endtask

  task automatic idle();
    rif.ramREN = 1'b0;
    rif.ramWEN = 1'b0;
  endtask

  // Full LAT=2 access: BUSY, BUSY, ACCESS, then release and expect FREE.
  task automatic op(input string tag, input logic ren, input word_t a, input word_t d,
                    input word_t exp_load);
    drive(ren, !ren, a, d);
    step(); chk_st({tag, " busy1"}, BUSY);
    step(); chk_st({tag, " busy2"}, BUSY);
    step(); chk_st({tag, " access"}, ACCESS);
    chk({tag, " load"}, rif.ramload, exp_load);
    idle();
    step(); chk_st({tag, " free"}, FREE);
    chk({tag, " load hold"}, rif.ramload, exp_load);
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b1, 1'b0, 32'h40, 32'h0);

    // Reset held with a read pending
    step(); chk_st("rst st1", FREE); chk("rst load1", rif.ramload, 32'h0);
    step(); chk_st("rst st2", FREE); chk("rst load2", rif.ramload, 32'h0);
    RST = 1'b0;
    step(); chk_st("post rst busy", BUSY);
    idle();
    step(); chk_st("drop abort free", FREE); chk("drop load", rif.ramload, 32'h0);

    // Write then read back
    op("wr40", 1'b0, 32'h40, 32'hDEADBEEF, 32'h0);
    op("rd40", 1'b1, 32'h40, 32'h0, 32'hDEADBEEF);

    // Seed words for abort and illegal checks
    op("wr80", 1'b0, 32'h80, 32'h11111111, 32'hDEADBEEF);
    op("wr84", 1'b0, 32'h84, 32'h22222222, 32'hDEADBEEF);
    op("wr00", 1'b0, 32'h00, 32'h55555555, 32'hDEADBEEF);

    // Read abort: address changes after one BUSY cycle
    drive(1'b1, 1'b0, 32'h80, 32'h0);
    step(); chk_st("rab busy1", BUSY);
    rif.ramaddr = 32'h84;
    step(); chk_st("rab restart1", BUSY);
    step(); chk_st("rab restart2", BUSY);
    step(); chk_st("rab access", ACCESS); chk("rab load", rif.ramload, 32'h22222222);
    idle();
    step(); chk_st("rab free", FREE);

    // Write abort just before completion
    drive(1'b0, 1'b1, 32'h80, 32'h33333333);
    step(); chk_st("wab busy1", BUSY);
    step(); chk_st("wab busy2", BUSY);
    idle();
    step(); chk_st("wab free", FREE);
    op("rd80 after abort", 1'b1, 32'h80, 32'h0, 32'h11111111);

    // Both read and write asserted
    drive(1'b1, 1'b1, 32'h40, 32'h0);
    step(); chk_st("both err1", ERROR);
    step(); chk_st("both err2", ERROR);
    idle();
    step(); chk_st("both free", FREE);

    // Misaligned and out-of-range writes (both would alias word 0)
    drive(1'b0, 1'b1, 32'h2, 32'hAAAAAAAA);
    step(); chk_st("misal err", ERROR);
    idle();
    step(); chk_st("misal free", FREE);
    drive(1'b0, 1'b1, 32'd4096, 32'hBBBBBBBB);
    step(); chk_st("oor err", ERROR);
    step(); chk_st("oor err held", ERROR);
    idle();
    step(); chk_st("oor free", FREE);
    op("rd00 intact", 1'b1, 32'h00, 32'h0, 32'h55555555);

    // Read held through ACCESS repeats
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    step(); chk_st("held b1", BUSY);
    step(); chk_st("held b2", BUSY);
    step(); chk_st("held a1", ACCESS); chk("held load1", rif.ramload, 32'hDEADBEEF);
    step(); chk_st("held b3", BUSY);
    step(); chk_st("held b4", BUSY);
    step(); chk_st("held a2", ACCESS); chk("held load2", rif.ramload, 32'hDEADBEEF);
    idle();
    step(); chk_st("held free", FREE);

    // Reset during the second BUSY cycle of a write
    drive(1'b0, 1'b1, 32'h40, 32'h12345678);
    step(); chk_st("mrst busy1", BUSY);
    step(); chk_st("mrst busy2", BUSY);
    RST = 1'b1;
    step(); chk_st("mrst free", FREE); chk("mrst load", rif.ramload, 32'h0);
    RST = 1'b0;
    idle();
    step(); chk_st("mrst idle", FREE);
    op("rd40 after mrst", 1'b1, 32'h40, 32'h0, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the RAM request interface driven by the cache/memory arbiter.
- Accepts ramREN/ramWEN/ramaddr/ramstore, models a single-port word RAM with fixed access latency, and returns ramload plus ramstate (FREE/BUSY/ACCESS/ERROR).
- The arbiter derives iwait/dwait from ramstate.
- Used as the simulation and FPGA RAM behind the arbiter.

Parameters:
LAT, 2, access latency in cycles spent in BUSY before ACCESS; legal range 1..15
DEPTH, 1024, storage size in 32-bit words; power of two

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, synchronous, active-high
ramREN  input  1  read request
ramWEN  input  1  write request
ramaddr  input  32  byte address; word index = ramaddr[log2(DEPTH)+1:2]
ramstore  input  32  write data
ramload  output  32  read data (registered)
ramstate  output  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Interface clocking:
  - One clock domain.
  - Reset is synchronous and active-high: sampled only on the CLK rising edge.
- Reset values:
  - ramstate = FREE, ramload = 0, latency counter = 0, latched address/op/data = 0.
  - Storage contents are not reset.
- Request: req = ramREN | ramWEN. A request is legal only when all of these hold:
  - not (ramREN & ramWEN)
  - ramaddr[1:0] == 0
  - ramaddr < DEPTH*4
- Request evaluation happens in FREE, and in ACCESS with req held:
  - no req -> FREE
  - illegal req -> ERROR
  - legal req -> BUSY; latch addr, op and ramstore; counter = LAT-1
- BUSY:
  - If req drops, or ramaddr, op or ramstore differs from the latched values, the access aborts and no write occurs. Re-evaluate the current inputs in that same cycle as from FREE; a changed legal request restarts BUSY with a full LAT.
  - Otherwise, counter != 0 -> decrement and stay in BUSY; counter == 0 -> ACCESS.
- ACCESS (exactly one cycle):
  - Write: storage[index] is updated on the edge entering ACCESS; ramload is unchanged.
  - Read: ramload = storage[index], registered on the edge entering ACCESS, so it is valid throughout ACCESS. ramload holds that value until the next read completes.
  - On leaving ACCESS, apply request evaluation. A held request is a new request: the requester deasserts the cycle after ACCESS, otherwise the operation repeats.
- ERROR:
  - Held while req is asserted, with no storage access.
  - On req = 0 -> FREE.
- Latency: a legal request seen in FREE at edge N gives BUSY during cycles N+1..N+LAT and ACCESS during cycle N+LAT+1.
- RST asserted mid-BUSY:
  - Abort with no write; next state FREE.
  - ramload returns to 0.
- ramstate is a registered state output, never combinational from the inputs.

Decomposition:
- cpu_types_pkg already holds ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t; use both.
- Add RAM_DEFAULT_LAT = 2 to cpu_types_pkg.
- Sub-module ram_array: single-port synchronous word storage (CLK, wen, windex, wdata, rindex, rdata registered).
- ram_responder holds the FSM, counter, request latch and legality checks.

Test Plan:
- Reset: RST=1 for 2 cycles with ramREN=1 -> ramstate=FREE, ramload=0 throughout; after release the request starts (BUSY next cycle).
- Write then read, LAT=2:
  - Write: ramWEN=1, addr=0x40, store=0xDEADBEEF -> BUSY 2 cycles, ACCESS 1 cycle; drop ramWEN after ACCESS -> FREE.
  - Read: ramREN=1, addr=0x40 -> ACCESS on the 3rd cycle with ramload=0xDEADBEEF.
- Abort: read 0x80 is pending after writing 0x11111111; after 1 BUSY cycle change addr to 0x84, which holds 0x22222222 -> BUSY restarts for 2 more cycles, ACCESS returns 0x22222222. Separately, a write aborted mid-BUSY leaves the old value readable.
- Illegal requests:
  - ramREN=ramWEN=1 -> ERROR next cycle, held while asserted, FREE the cycle after deassert.
  - addr=0x2 (misaligned) and addr=DEPTH*4 (out of range) -> ERROR, storage unchanged.
- Held request: ramREN held through ACCESS at addr 0x40 -> pattern BUSY,BUSY,ACCESS,BUSY,BUSY,ACCESS; ramload=0xDEADBEEF both times.
- Mid-op reset: write 0x40 := 0x12345678 with RST pulsed during the 2nd BUSY cycle -> FREE, ramload=0; a subsequent read of 0x40 returns 0xDEADBEEF (no write occurred).
